// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and width helper for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority selector, first set request at or above ptr with wrap.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic                any_req,
    output logic [ID_WIDTH-1:0] sel_id
);

    logic [2*NUM_REQ-1:0] dbl;

    // Doubling the vector turns the wrap into a plain lowest-set-bit search.
    always_comb begin
        dbl     = {req, req} & ~(((2*NUM_REQ)'(1) << ptr) - (2*NUM_REQ)'(1));
        any_req = |req;
        sel_id  = '0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--)
            if (dbl[i]) sel_id = ID_WIDTH'(i % NUM_REQ);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one sync FIFO write port
// among NUM_REQ producers, never writing while the FIFO is full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
);

    localparam int BW = clog2(MAX_BURST) + 1;

    state_t              state, state_n;
    logic [ID_WIDTH-1:0] rr_ptr, pick;
    logic [BW-1:0]       beat_cnt;
    logic                any_req, granted, beat, rel;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .any_req (any_req),
        .sel_id  (pick)
    );

    assign granted      = state == GRANT;
    // rst masks the outputs so an in-flight beat is dropped on the reset edge.
    assign beat         = granted && req_valid[grant_id] && !fifo_full && !rst;
    assign rel          = granted && (!req_valid[grant_id] || (beat && beat_cnt == BW'(MAX_BURST-1)));
    assign req_ready    = (granted && !fifo_full && !rst) ? (NUM_REQ'(1) << grant_id) : '0;
    assign fifo_wr_en   = beat;
    assign fifo_wr_data = granted ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign busy         = granted;

    always_comb
        state_n = (state == IDLE) ? (any_req ? GRANT : IDLE) : (rel ? IDLE : GRANT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && any_req) begin
                grant_id <= pick;
                beat_cnt <= '0;
            end
            if (rel)
                rr_ptr <= (grant_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
            else if (beat)
                beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that lets NUM_REQ independent producers share one synchronous FIFO write port. It sits directly in front of the team's sync FIFO: it selects one requester, grants it a bounded burst of writes, and drives the FIFO's wr_en/wr_data while respecting full. The grant rotates fairly so that no requester starves.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- DATA_WIDTH, 8: write data width; matches the FIFO
- MAX_BURST, 4: maximum beats per grant, ≥1
- ID_WIDTH, 2: width of grant_id; equals clog2(NUM_REQ)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*DATA_WIDTH  flat bus; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set
- fifo_wr_en  out  1  to FIFO wr_en
- fifo_wr_data  out  DATA_WIDTH  to FIFO wr_data
- fifo_full  in  1  from FIFO full
- grant_id  out  ID_WIDTH  index of the current or last granted requester
- busy  out  1  high while in GRANT

## Operation
- Two states: IDLE and GRANT.
- IDLE: if any req_valid is set, pick the first set bit at or above rr_ptr, wrapping modulo NUM_REQ. Register it into grant_id, clear beat_cnt, go to GRANT. If no req_valid is set, stay in IDLE.
- GRANT, with g = grant_id:
  - req_ready[g] = !fifo_full. All other ready bits are 0.
  - fifo_wr_en = req_valid[g] && !fifo_full.
  - fifo_wr_data = req_data slice g. It is don't-care when wr_en=0 but is still driven from slice g.
  - A beat is a cycle with fifo_wr_en=1. beat_cnt increments on each beat.
- Release from GRANT to IDLE on the next edge when either:
  - req_valid[g]=0, or
  - a beat occurs with beat_cnt==MAX_BURST-1.
- On release, rr_ptr <= (g+1) mod NUM_REQ.
- fifo_full in GRANT stalls the burst. The grant is held, beat_cnt holds, and nothing is written. If req_valid[g] drops while full, release still occurs.
- No write is ever issued while fifo_full=1. The arbiter never over-fills the FIFO.
- Valid/ready rule: a requester must hold req_valid and its data stable until it sees ready. Dropping valid ends its grant.
- beat_cnt width is clog2(MAX_BURST)+1, so MAX_BURST=1 is legal. With MAX_BURST=1 every grant is one beat.
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, busy=0.
  - req_ready=0, fifo_wr_en=0, fifo_wr_data=0 (driven from slice 0 gated by state).
- Reset mid-burst: the next edge returns to IDLE with all of the values above. Any in-flight beat on that edge is not issued, because wr_en is forced 0 while rst=1.

## Timing
- Arbitration takes 1 cycle. A requester asserting valid in cycle N in IDLE sees ready in cycle N+1, provided the FIFO is not full.
- Data path is combinational from req_data and req_valid to fifo_wr_*. The FIFO registers it on the same edge.
- There is one IDLE bubble between grants. Sustained throughput with all requesters busy is MAX_BURST/(MAX_BURST+1) beats per cycle.
- fifo_full to req_ready and fifo_wr_en is combinational, same cycle.
- Worst-case wait for a continuously valid requester is (NUM_REQ-1)*(MAX_BURST+1)+1 cycles, excluding full stalls.

## Structure
- Shared package fifo_arb_pkg holds:
  - the state encoding constants (IDLE=0, GRANT=1);
  - a clog2 function used for ID_WIDTH and beat_cnt width.
- Sub-module rr_pick: combinational rotating-priority selector.
  - Inputs: req vector, rr_ptr.
  - Outputs: any_req, sel_id.
  - Implemented as mask-and-double-vector priority encode.
- The FIFO itself is instantiated by the parent, not inside this block.

## Test plan
- Reset and single burst: NUM_REQ=4, MAX_BURST=4, rst high 2 cycles. Then req_valid=0001 with data 0x10..0x13 → busy rises 1 cycle later, 4 writes 0x10..0x13 on consecutive cycles, release, rr_ptr=1.
- Fair rotation: all four valid continuously, each pushing its index as data → FIFO order is 4×0, 4×1, 4×2, 4×3, 4×0, with one bubble per grant.
- Full stall: grant requester 2, assert fifo_full after its 2nd beat for 3 cycles → wr_en=0 and ready=0 for those 3 cycles, grant_id stays 2, remaining 2 beats follow. Total beats = 4, none lost or duplicated.
- Early release: requester 1 valid for only 2 beats, requester 3 waiting → after 2 writes, IDLE for 1 cycle, then grant_id=3.
- Wrap-around: rr_ptr=3 with req_valid=1001 → grant goes to 3, then to 0.
- Reset mid-burst: assert rst on the 3rd beat of a burst → no write on that edge, all outputs at reset values next cycle, next grant search starts from requester 0.
